// File: rtl/avalon_slave_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// avalon_pkg
// Shared definitions for the Avalon-style interconnect: bus field widths and
// the per-slave arbiter state encoding.
// -----------------------------------------------------------------------------
package avalon_pkg;

    localparam int AV_ADDR_W = 30;   // word address width
    localparam int AV_DATA_W = 32;   // data width
    localparam int AV_BE_W   = 4;    // byte-enable width

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage : avalon_pkg

// File: rtl/avalon_slave_arbiter_if.sv
// -----------------------------------------------------------------------------
// avalon_slave_arbiter_if
// Bus bundle between NUM_MASTERS masters, one slave and the per-slave arbiter.
//   i_AVIn_*   : packed master-side request fields (one slice per master)
//   o_AVIn_*   : per-master read data / waitrequest returned by the arbiter
//   o_AVOut_*  : request forwarded to the slave
//   i_AVOut_*  : slave response
// Modports:
//   slave  - arbiter view (it is the slave seen by the masters)
//   master - environment view (masters + slave model / crossbar)
// -----------------------------------------------------------------------------
interface avalon_slave_arbiter_if #(
    parameter int NUM_MASTERS = 2
);
    import avalon_pkg::*;

    logic [AV_ADDR_W*NUM_MASTERS-1:0] i_AVIn_Addr;
    logic [AV_BE_W*NUM_MASTERS-1:0]   i_AVIn_ByteEn;
    logic [NUM_MASTERS-1:0]           i_AVIn_Read;
    logic [NUM_MASTERS-1:0]           i_AVIn_Write;
    logic [AV_DATA_W*NUM_MASTERS-1:0] i_AVIn_WriteData;
    logic [AV_DATA_W*NUM_MASTERS-1:0] o_AVIn_ReadData;
    logic [NUM_MASTERS-1:0]           o_AVIn_WaitRequest;

    logic [AV_ADDR_W-1:0]             o_AVOut_Addr;
    logic [AV_BE_W-1:0]               o_AVOut_ByteEn;
    logic                             o_AVOut_Read;
    logic                             o_AVOut_Write;
    logic [AV_DATA_W-1:0]             o_AVOut_WriteData;
    logic [AV_DATA_W-1:0]             i_AVOut_ReadData;
    logic                             i_AVOut_WaitRequest;

    modport slave (
        input  i_AVIn_Addr, i_AVIn_ByteEn, i_AVIn_Read, i_AVIn_Write,
               i_AVIn_WriteData, i_AVOut_ReadData, i_AVOut_WaitRequest,
        output o_AVIn_ReadData, o_AVIn_WaitRequest, o_AVOut_Addr,
               o_AVOut_ByteEn, o_AVOut_Read, o_AVOut_Write, o_AVOut_WriteData
    );

    modport master (
        output i_AVIn_Addr, i_AVIn_ByteEn, i_AVIn_Read, i_AVIn_Write,
               i_AVIn_WriteData, i_AVOut_ReadData, i_AVOut_WaitRequest,
        input  o_AVIn_ReadData, o_AVIn_WaitRequest, o_AVOut_Addr,
               o_AVOut_ByteEn, o_AVOut_Read, o_AVOut_Write, o_AVOut_WriteData
    );

endinterface : avalon_slave_arbiter_if

// File: rtl/avalon_slave_arbiter_rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin pick: the first asserted request at or after the
// pointer, wrapping modulo NUM_MASTERS.
//   req_i   : request vector
//   ptr_i   : index with highest priority this round (< NUM_MASTERS)
//   grant_o : one-hot pick (zero when no request)
//   idx_o   : index of the pick
//   valid_o : at least one request present
// -----------------------------------------------------------------------------
module rr_priority_picker #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]       ptr_i,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic [IDX_W-1:0]       idx_o,
    output logic                   valid_o
);

    // One spare bit so ptr + offset cannot overflow before the wrap.
    localparam int CW = IDX_W + 1;

    logic [CW-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = {1'b0, ptr_i} + CW'(i);
            if (cand >= CW'(NUM_MASTERS)) begin
                cand = cand - CW'(NUM_MASTERS);
            end
            if (!valid_o && req_i[cand[IDX_W-1:0]]) begin
                valid_o                 = 1'b1;
                idx_o                   = cand[IDX_W-1:0];
                grant_o[cand[IDX_W-1:0]] = 1'b1;
            end
        end
    end

endmodule : rr_priority_picker

// File: rtl/avalon_slave_arbiter.sv
// -----------------------------------------------------------------------------
// avalon_slave_arbiter
// Per-slave round-robin arbiter. Shares one slave among NUM_MASTERS masters;
// the grant is held until the slave accepts (waitrequest low). Read data is
// registered and returned only on the completing master's slice for a single
// cycle, so results from several slaves can be OR-reduced by the crossbar.
//   i_Clk   : rising-edge clock
//   i_Rst_n : asynchronous active-low reset
//   bus     : avalon_slave_arbiter_if.slave (master requests, slave port)
//   o_Grant : one-hot current grant (debug/perf)
// -----------------------------------------------------------------------------
module avalon_slave_arbiter
    import avalon_pkg::*;
#(
    parameter int          NUM_MASTERS  = 2,
    parameter int          SEL_NUM_BITS = 1,
    parameter logic [29:0] SEL_VAL      = 30'd0
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_n,
    avalon_slave_arbiter_if.slave         bus,
    output logic [NUM_MASTERS-1:0]        o_Grant
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    logic [AV_ADDR_W-1:0]   m_addr  [NUM_MASTERS];
    logic [AV_BE_W-1:0]     m_be    [NUM_MASTERS];
    logic [AV_DATA_W-1:0]   m_wdata [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] req;

    arb_state_t                       state_q;
    logic [NUM_MASTERS-1:0]           grant_q;
    logic [IDX_W-1:0]                 gidx_q;
    logic [IDX_W-1:0]                 ptr_q;
    logic [IDX_W-1:0]                 ptr_d;
    logic [AV_DATA_W*NUM_MASTERS-1:0] rdata_q;

    logic [NUM_MASTERS-1:0] pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;

    logic                   busy;
    logic                   req_g;
    logic                   rd_g;
    logic                   complete;
    logic [NUM_MASTERS-1:0] done_mask;

    for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_unpack
        assign m_addr[m]  = bus.i_AVIn_Addr[m*AV_ADDR_W +: AV_ADDR_W];
        assign m_be[m]    = bus.i_AVIn_ByteEn[m*AV_BE_W +: AV_BE_W];
        assign m_wdata[m] = bus.i_AVIn_WriteData[m*AV_DATA_W +: AV_DATA_W];
        assign req[m]     = (bus.i_AVIn_Read[m] | bus.i_AVIn_Write[m]) &
                            (m_addr[m][AV_ADDR_W-1 -: SEL_NUM_BITS] ==
                             SEL_VAL[SEL_NUM_BITS-1:0]);
    end

    rr_priority_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign busy     = (state_q == ARB_BUSY);
    // A master that withdraws (strobes low or address moved away) aborts.
    assign req_g    = |(req & grant_q);
    assign rd_g     = bus.i_AVIn_Read[gidx_q];
    assign complete = busy && req_g && !bus.i_AVOut_WaitRequest;
    assign ptr_d    = (gidx_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : gidx_q + IDX_W'(1);

    // Only the granted master is released, and only when the slave accepts.
    assign done_mask              = (busy && !bus.i_AVOut_WaitRequest) ? grant_q : '0;
    assign bus.o_AVIn_WaitRequest = req & ~done_mask;
    assign bus.o_AVIn_ReadData    = rdata_q;
    assign o_Grant                = grant_q;

    always_comb begin
        bus.o_AVOut_Addr      = '0;
        bus.o_AVOut_ByteEn    = '0;
        bus.o_AVOut_Read      = 1'b0;
        bus.o_AVOut_Write     = 1'b0;
        bus.o_AVOut_WriteData = '0;
        if (busy && req_g) begin
            bus.o_AVOut_Addr      = m_addr[gidx_q];
            bus.o_AVOut_ByteEn    = m_be[gidx_q];
            bus.o_AVOut_Read      = rd_g;
            // Read wins if a master raises both strobes.
            bus.o_AVOut_Write     = bus.i_AVIn_Write[gidx_q] & ~rd_g;
            bus.o_AVOut_WriteData = m_wdata[gidx_q];
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            rdata_q <= '0;
        end else begin
            // Read data lives for exactly one cycle on the completing slice.
            for (int m = 0; m < NUM_MASTERS; m++) begin
                rdata_q[m*AV_DATA_W +: AV_DATA_W] <=
                    (complete && rd_g && grant_q[m]) ? bus.i_AVOut_ReadData : '0;
            end
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        state_q <= ARB_BUSY;
                        grant_q <= pick_grant;
                        gidx_q  <= pick_idx;
                    end
                end
                ARB_BUSY: begin
                    if (!req_g) begin
                        state_q <= ARB_IDLE;
                        grant_q <= '0;
                    end else if (!bus.i_AVOut_WaitRequest) begin
                        state_q <= ARB_IDLE;
                        grant_q <= '0;
                        ptr_q   <= ptr_d;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule : avalon_slave_arbiter

// File: tb/tb_avalon_slave_arbiter.sv
// -----------------------------------------------------------------------------
// tb_avalon_slave_arbiter
// Self-checking bench for avalon_slave_arbiter with two masters, a one-bit
// select and SEL_VAL=0. Read data expectations travel through a scoreboard.
// -----------------------------------------------------------------------------
module tb_avalon_slave_arbiter;

    localparam int NM = 2;

    logic          i_Clk;
    logic          i_Rst_n;
    logic [NM-1:0] grant;

    avalon_slave_arbiter_if #(.NUM_MASTERS(NM)) bus ();

    avalon_slave_arbiter #(
        .NUM_MASTERS  (NM),
        .SEL_NUM_BITS (1),
        .SEL_VAL      (30'd0)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .bus     (bus),
        .o_Grant (grant)
    );

    typedef struct {
        int          m;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, got timeout want finish");
        $fatal(1);
    end

    task automatic clear_inputs();
        bus.i_AVIn_Addr         = '0;
        bus.i_AVIn_ByteEn       = '0;
        bus.i_AVIn_Read         = '0;
        bus.i_AVIn_Write        = '0;
        bus.i_AVIn_WriteData    = '0;
        bus.i_AVOut_ReadData    = '0;
        bus.i_AVOut_WaitRequest = 1'b0;
    endtask

    task automatic set_master(input int m, input logic rd, input logic wr,
                              input logic [29:0] addr, input logic [31:0] wdata);
        bus.i_AVIn_Addr[m*30 +: 30]      = addr;
        bus.i_AVIn_ByteEn[m*4 +: 4]      = 4'hF;
        bus.i_AVIn_Read[m]               = rd;
        bus.i_AVIn_Write[m]              = wr;
        bus.i_AVIn_WriteData[m*32 +: 32] = wdata;
    endtask

    task automatic do_reset();
        i_Rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge i_Clk);
        @(negedge i_Clk);
        i_Rst_n = 1'b1;
    endtask

    // Read through the arbiter; expected data goes into the scoreboard when driven.
    task automatic do_read(input int m, input logic [29:0] addr, input logic [31:0] data);
        int   n;
        exp_t e;
        int   om;
        om = (m == 0) ? 1 : 0;
        @(posedge i_Clk); #1;
        set_master(m, 1'b1, 1'b0, addr, 32'h0);
        bus.i_AVOut_ReadData = data;
        sb.push_back('{m: m, d: data});
        n = 0;
        do begin
            @(negedge i_Clk);
            n++;
        end while (bus.o_AVIn_WaitRequest[m] && n < 20);
        n_total++;
        if (bus.o_AVIn_WaitRequest[m]) $display("FAIL rd_timeout m%0d: got waitrequest 1 want 0 within 20 cycles", m);
        else n_pass++;
        n_total++;
        if (n !== 2) $display("FAIL rd_latency m%0d: got %0d want 2", m, n);
        else n_pass++;
        n_total++;
        if (bus.o_AVOut_Addr !== addr || bus.o_AVOut_Read !== 1'b1)
            $display("FAIL rd_slave_req m%0d: got addr %h rd %b want %h 1", m, bus.o_AVOut_Addr, bus.o_AVOut_Read, addr);
        else n_pass++;
        n_total++;
        if (grant !== NM'(1 << m)) $display("FAIL rd_grant m%0d: got %b want %b", m, grant, NM'(1 << m));
        else n_pass++;
        @(posedge i_Clk); #1;
        set_master(m, 1'b0, 1'b0, 30'h0, 32'h0);
        @(negedge i_Clk);
        e = sb.pop_front();
        n_total++;
        if (bus.o_AVIn_ReadData[e.m*32 +: 32] !== e.d)
            $display("FAIL rd_data m%0d: got %h want %h", e.m, bus.o_AVIn_ReadData[e.m*32 +: 32], e.d);
        else n_pass++;
        n_total++;
        if (bus.o_AVIn_ReadData[om*32 +: 32] !== 32'h0)
            $display("FAIL rd_other m%0d: got %h want 0", om, bus.o_AVIn_ReadData[om*32 +: 32]);
        else n_pass++;
        @(negedge i_Clk);
        n_total++;
        if (bus.o_AVIn_ReadData[m*32 +: 32] !== 32'h0)
            $display("FAIL rd_clear m%0d: got %h want 0", m, bus.o_AVIn_ReadData[m*32 +: 32]);
        else n_pass++;
    endtask

    task automatic test_reset();
        i_Rst_n = 1'b0;
        clear_inputs();
        set_master(0, 1'b1, 1'b0, 30'h0, 32'h0);
        bus.i_AVOut_WaitRequest = 1'b1;
        @(posedge i_Clk);
        @(negedge i_Clk);
        n_total++;
        if (bus.o_AVOut_Read !== 1'b0) $display("FAIL reset_slave_rd: got %b want 0", bus.o_AVOut_Read);
        else n_pass++;
        n_total++;
        if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant);
        else n_pass++;
        n_total++;
        if (bus.o_AVIn_WaitRequest[0] !== 1'b1) $display("FAIL reset_wait0: got %b want 1", bus.o_AVIn_WaitRequest[0]);
        else n_pass++;
        n_total++;
        if (bus.o_AVIn_ReadData !== 64'h0) $display("FAIL reset_rdata: got %h want 0", bus.o_AVIn_ReadData);
        else n_pass++;
        i_Rst_n = 1'b1;
        @(negedge i_Clk);
        n_total++;
        if (grant !== 2'b01) $display("FAIL reset_release_grant: got %b want 01", grant);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        do_read(1, 30'h1, 32'hDEADBEEF);
    endtask

    task automatic test_back_to_back();
        do_reset();
        do_read(0, 30'h3, 32'h1111_2222);
        do_read(1, 30'h7, 32'h3333_4444);
        do_read(0, 30'h1FFF_FFFF, 32'h0F0F_A5A5);
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [8];
        int w0;
        int w1;
        exp_g = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        w0 = 0;
        w1 = 0;
        do_reset();
        @(posedge i_Clk); #1;
        set_master(0, 1'b0, 1'b1, 30'h10, 32'hA0A0_0000);
        set_master(1, 1'b0, 1'b1, 30'h20, 32'hB1B1_1111);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(posedge i_Clk);
            @(negedge i_Clk);
            if (!bus.o_AVIn_WaitRequest[0]) w0++;
            if (!bus.o_AVIn_WaitRequest[1]) w1++;
            n_total++;
            if (grant !== exp_g[c]) $display("FAIL cont_grant c%0d: got %b want %b", c, grant, exp_g[c]);
            else n_pass++;
            if (exp_g[c] == 2'b01) begin
                n_total++;
                if (bus.o_AVOut_Write !== 1'b1 || bus.o_AVOut_WriteData !== 32'hA0A0_0000)
                    $display("FAIL cont_wdata0 c%0d: got wr %b data %h want 1 a0a00000", c, bus.o_AVOut_Write, bus.o_AVOut_WriteData);
                else n_pass++;
            end else if (exp_g[c] == 2'b10) begin
                n_total++;
                if (bus.o_AVOut_Write !== 1'b1 || bus.o_AVOut_WriteData !== 32'hB1B1_1111)
                    $display("FAIL cont_wdata1 c%0d: got wr %b data %h want 1 b1b11111", c, bus.o_AVOut_Write, bus.o_AVOut_WriteData);
                else n_pass++;
            end
        end
        n_total++;
        if (w0 !== 2) $display("FAIL cont_wait0_count: got %0d want 2", w0);
        else n_pass++;
        n_total++;
        if (w1 !== 2) $display("FAIL cont_wait1_count: got %0d want 2", w1);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        @(posedge i_Clk); #1;
        bus.i_AVOut_WaitRequest = 1'b1;
        set_master(0, 1'b0, 1'b1, 30'h5, 32'hCAFE_F00D);
        set_master(1, 1'b0, 1'b1, 30'h9, 32'h1234_5678);
        for (int c = 1; c <= 6; c++) begin
            @(posedge i_Clk); #1;
            if (c == 6) bus.i_AVOut_WaitRequest = 1'b0;
            @(negedge i_Clk);
            n_total++;
            if (grant !== 2'b01 || bus.o_AVOut_Addr !== 30'h5 || bus.o_AVOut_Write !== 1'b1 ||
                bus.o_AVOut_WriteData !== 32'hCAFE_F00D)
                $display("FAIL stall_slave c%0d: got g %b a %h w %b d %h want 01 5 1 cafef00d",
                         c, grant, bus.o_AVOut_Addr, bus.o_AVOut_Write, bus.o_AVOut_WriteData);
            else n_pass++;
            n_total++;
            if (bus.o_AVIn_WaitRequest !== ((c < 6) ? 2'b11 : 2'b10))
                $display("FAIL stall_wait c%0d: got %b want %b", c, bus.o_AVIn_WaitRequest, (c < 6) ? 2'b11 : 2'b10);
            else n_pass++;
        end
        @(posedge i_Clk); #1;
        set_master(0, 1'b0, 1'b0, 30'h0, 32'h0);
        @(negedge i_Clk);
        n_total++;
        if (grant !== 2'b00) $display("FAIL stall_idle: got %b want 00", grant);
        else n_pass++;
        @(negedge i_Clk);
        n_total++;
        if (grant !== 2'b10 || bus.o_AVOut_Addr !== 30'h9)
            $display("FAIL stall_next: got g %b a %h want 10 9", grant, bus.o_AVOut_Addr);
        else n_pass++;
        @(posedge i_Clk); #1;
        clear_inputs();
    endtask

    task automatic test_addr_miss();
        do_reset();
        @(posedge i_Clk); #1;
        set_master(0, 1'b1, 1'b0, 30'h2000_0004, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge i_Clk);
            n_total++;
            if (bus.o_AVIn_WaitRequest[0] !== 1'b0 || grant !== 2'b00 ||
                bus.o_AVOut_Read !== 1'b0 || bus.o_AVOut_Addr !== 30'h0)
                $display("FAIL miss c%0d: got w %b g %b rd %b a %h want 0 00 0 0",
                         c, bus.o_AVIn_WaitRequest[0], grant, bus.o_AVOut_Read, bus.o_AVOut_Addr);
            else n_pass++;
        end
        clear_inputs();
    endtask

    task automatic test_abort_and_reset();
        do_reset();
        @(posedge i_Clk); #1;
        bus.i_AVOut_WaitRequest = 1'b1;
        set_master(0, 1'b1, 1'b0, 30'h2, 32'h0);
        @(negedge i_Clk);
        @(negedge i_Clk);
        n_total++;
        if (grant !== 2'b01) $display("FAIL abort_grant: got %b want 01", grant);
        else n_pass++;
        set_master(0, 1'b0, 1'b0, 30'h2, 32'h0);
        @(negedge i_Clk);
        n_total++;
        if (grant !== 2'b00) $display("FAIL abort_idle: got %b want 00", grant);
        else n_pass++;
        // Pointer must still favour master 0 when both request.
        bus.i_AVOut_WaitRequest = 1'b0;
        set_master(0, 1'b1, 1'b0, 30'h2, 32'h0);
        set_master(1, 1'b1, 1'b0, 30'h3, 32'h0);
        @(negedge i_Clk);
        n_total++;
        if (grant !== 2'b01) $display("FAIL abort_ptr: got %b want 01", grant);
        else n_pass++;
        clear_inputs();

        do_reset();
        @(posedge i_Clk); #1;
        bus.i_AVOut_WaitRequest = 1'b1;
        set_master(0, 1'b0, 1'b1, 30'h4, 32'h5555_AAAA);
        @(negedge i_Clk);
        @(negedge i_Clk);
        n_total++;
        if (bus.o_AVOut_Write !== 1'b1 || grant !== 2'b01)
            $display("FAIL midrst_busy: got wr %b g %b want 1 01", bus.o_AVOut_Write, grant);
        else n_pass++;
        i_Rst_n = 1'b0;
        #1;
        n_total++;
        if (grant !== 2'b00 || bus.o_AVOut_Write !== 1'b0)
            $display("FAIL midrst_clear: got g %b wr %b want 00 0", grant, bus.o_AVOut_Write);
        else n_pass++;
        n_total++;
        if (bus.o_AVIn_WaitRequest[0] !== 1'b1)
            $display("FAIL midrst_wait: got %b want 1", bus.o_AVIn_WaitRequest[0]);
        else n_pass++;
        clear_inputs();
        @(negedge i_Clk);
        i_Rst_n = 1'b1;
    endtask

    initial begin
        i_Rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_contention();
        test_stall();
        test_addr_miss();
        test_abort_and_reset();
        n_total++;
        if (sb.size() !== 0) $display("FAIL sb_empty: got %0d entries want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_avalon_slave_arbiter
